// File: rtl/bcd_countdown_timer_pkg.sv
// rtl/bcd_countdown_timer_pkg.sv - shared types and constants for the BCD countdown timer
package bcd_countdown_timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    // Out-of-range BCD nibbles (A-F) are treated as 9
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - single BCD decade down-counter with clamped parallel load
module bcd_down_digit
    import bcd_countdown_timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] Q,
    output logic               borrow_out
);

    // Load wins over decrement; 0 wraps to 9 and the borrow is signalled combinationally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q <= '0;
        end else if (load) begin
            Q <= clamp_digit(d);
        end else if (en) begin
            Q <= (Q == '0) ? BCD_MAX : Q - 4'd1;
        end
    end

    // Borrow into the next decade only when this digit is wrapping
    always_comb begin
        borrow_out = en & (Q == '0);
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - three-digit BCD countdown timer with load, start, pause and auto-reload
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int AUTO_RELOAD = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        load,
    input  logic [11:0] load_value,
    input  logic        start,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic        running,
    output logic        zero,
    output logic        done
);

    localparam bit RELOAD_ON = (AUTO_RELOAD != 0);

    state_t      state_q;
    state_t      state_n;
    logic        done_n;
    logic [11:0] reload_q;
    logic        is_one;
    logic        is_zero;
    logic        dec_en;
    logic        reload_now;
    logic        digit_load;
    logic [11:0] digit_d;
    logic        ones_borrow;
    logic        tens_borrow;
    logic        hundreds_borrow;

    // Count-value decodes and digit-chain control
    always_comb begin
        is_zero    = (hundreds == 4'd0) && (tens == 4'd0) && (ones == 4'd0);
        is_one     = (hundreds == 4'd0) && (tens == 4'd0) && (ones == 4'd1);
        // Expiry under auto-reload replaces the decrement with a reload of the period
        reload_now = RELOAD_ON && (state_q == RUN) && en && is_one && !load;
        dec_en     = (state_q == RUN) && en && !load && !reload_now;
        digit_load = load || reload_now;
        digit_d    = load ? load_value : reload_q;
    end

    bcd_down_digit u_ones (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (dec_en),
        .load       (digit_load),
        .d          (digit_d[3:0]),
        .Q          (ones),
        .borrow_out (ones_borrow)
    );

    bcd_down_digit u_tens (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (ones_borrow),
        .load       (digit_load),
        .d          (digit_d[7:4]),
        .Q          (tens),
        .borrow_out (tens_borrow)
    );

    bcd_down_digit u_hundreds (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (tens_borrow),
        .load       (digit_load),
        .d          (digit_d[11:8]),
        .Q          (hundreds),
        .borrow_out (hundreds_borrow)
    );

    // Reload register keeps the clamped value of the most recent load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= {clamp_digit(load_value[11:8]),
                         clamp_digit(load_value[7:4]),
                         clamp_digit(load_value[3:0])};
        end
    end

    // FSM state and registered done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            done    <= done_n;
        end
    end

    // Next-state logic: load > start > en
    always_comb begin
        state_n = state_q;
        done_n  = 1'b0;
        if (load) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (is_zero) begin
                            state_n = EXPIRED;
                            done_n  = 1'b1;
                        end else begin
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    if (en && is_one) begin
                        done_n = 1'b1;
                        if (!RELOAD_ON) begin
                            state_n = EXPIRED;
                        end
                    end else if (hundreds_borrow) begin
                        // Underflow past 000 is unreachable from legal sequences; park safely
                        state_n = EXPIRED;
                    end
                end
                EXPIRED: state_n = EXPIRED;
                default: state_n = IDLE;
            endcase
        end
    end

    // Status outputs
    always_comb begin
        running = (state_q == RUN);
        zero    = is_zero;
    end

endmodule
